// File: rtl/ctrl_encoder.sv
// ctrl_encoder: encodes a multi-hot control request into a 7-bit word
// (lowest set index, multi-bit flag, parity), stages it for one cycle and
// queues it in a DEPTH-entry FIFO toward a ready/valid consumer. All-zero
// requests are flagged with a one-cycle pulse and a saturating counter.
module ctrl_encoder #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned REQ_W = 26
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [REQ_W-1:0]         in_req,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [6:0]               out_code,
  output logic                     err_zero,
  output logic [7:0]               err_cnt,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [4:0]    low_idx;
  logic          multi;
  logic [6:0]    enc_code;
  logic          req_zero;
  logic          accept;
  logic          push;
  logic          pop;
  logic          s_valid;
  logic [6:0]    s_code;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW+1:0] fill;
  logic [6:0]    mem [DEPTH];

  // Lowest set bit index: scan from the top so the last hit is the lowest bit
  always_comb begin
    low_idx = '0;
    for (int unsigned i = REQ_W; i > 0; i--) begin
      if (in_req[i-1]) low_idx = 5'(i - 1);
    end
  end

  // Clearing the lowest set bit leaves something only if two or more were set
  assign multi    = |(in_req & (in_req - REQ_W'(1)));
  assign enc_code = {^{multi, low_idx}, multi, low_idx};
  assign req_zero = ~|in_req;

  // Room is judged on registered state only, reserving a slot for the stage
  assign fill      = {1'b0, occupancy} + {{(AW+1){1'b0}}, s_valid};
  assign in_ready  = rst_n & (fill < (AW+2)'(DEPTH));
  assign accept    = in_valid & in_ready;
  assign push      = s_valid;
  assign out_valid = (occupancy != '0);
  assign pop       = out_valid & out_ready;
  assign out_code  = out_valid ? mem[rd_ptr] : '0;

  // FIFO storage: written from the stage register, contents need no reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_code;
  end

  // Stage register, FIFO pointers/occupancy and zero-request bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_valid   <= 1'b0;
      s_code    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      err_zero  <= 1'b0;
      err_cnt   <= '0;
    end else begin
      s_valid  <= accept & ~req_zero;
      if (accept & ~req_zero) s_code <= enc_code;

      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   occupancy <= occupancy + (AW+1)'(1);
        2'b01:   occupancy <= occupancy - (AW+1)'(1);
        default: occupancy <= occupancy;
      endcase

      err_zero <= accept & req_zero;
      if (accept & req_zero & (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_ctrl_encoder.sv
// tb_ctrl_encoder: scoreboard bench for ctrl_encoder. Stimulus pushes
// expected words and err_zero cycles into queues on acceptance; a monitor on
// the falling edge pops and compares whatever the DUT presents.
module tb_ctrl_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [25:0] in_req;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  out_code;
  logic        err_zero;
  logic [7:0]  err_cnt;
  logic [2:0]  occupancy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int nzero   = 0;
  int n_pop   = 0;
  int n_pulse = 0;
  logic [6:0] exp_q [$];
  int         zero_q [$];

  ctrl_encoder #(.DEPTH(4), .REQ_W(26)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_req(in_req), .out_valid(out_valid), .out_ready(out_ready),
    .out_code(out_code), .err_zero(err_zero), .err_cnt(err_cnt),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference encoding from the rules: first set bit, popcount, parity
  function automatic logic [6:0] model(logic [25:0] r);
    logic [6:0] c;
    int lo;
    lo = -1;
    for (int b = 0; b < 26; b++) if (r[b] && lo < 0) lo = b;
    c[4:0] = lo[4:0];
    c[5]   = ($countones(r) >= 2);
    c[6]   = ($countones(c[5:0]) % 2) == 1;
    return c;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // One cycle of stimulus, called just after a rising edge
  task automatic step(logic v, logic [25:0] r, logic ordy);
    in_valid  = v;
    in_req    = r;
    out_ready = ordy;
    if (v && in_ready) begin
      if (r == '0) begin
        zero_q.push_back(cyc + 1);
        nzero++;
      end else begin
        exp_q.push_back(model(r));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [25:0] r, logic ordy);
    int k;
    k = 0;
    while (!in_ready && k < 50) begin
      step(1'b0, 26'($urandom), ordy);
      k++;
    end
    if (!in_ready) fail_now("in_ready_timeout");
    else step(1'b1, r, ordy);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || zero_q.size() != 0) && k < 64) begin
      step(1'b0, 26'($urandom), 1'b1);
      k++;
    end
    if (exp_q.size() != 0 || zero_q.size() != 0) fail_now("drain_timeout");
    step(1'b0, 26'($urandom), 1'b1);
  endtask

  function automatic logic [25:0] rand_req(bit allow_zero);
    logic [25:0] r;
    case ($urandom % 4)
      0:       r = allow_zero ? '0 : 26'd1;
      1:       r = 26'd1 << ($urandom % 26);
      default: r = 26'($urandom);
    endcase
    if (!allow_zero && r == '0) r = 26'd2;
    return r;
  endfunction

  // Monitor: compares the presented head and err_zero timing against queues
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_word");
        end else begin
          check("out_code", 32'(out_code), 32'(exp_q[0]));
          if (out_ready) begin
            void'(exp_q.pop_front());
            n_pop++;
          end
        end
      end
      if (err_zero) begin
        if (zero_q.size() == 0) begin
          fail_now("spurious_err_zero");
        end else begin
          check("err_zero_cycle", 32'(cyc), 32'(zero_q[0]));
          void'(zero_q.pop_front());
          n_pulse++;
        end
      end else if (zero_q.size() != 0 && zero_q[0] <= cyc) begin
        fail_now("missing_err_zero");
        void'(zero_q.pop_front());
      end
    end
  end

  initial begin
    logic [25:0] vec [4];
    logic [6:0]  vcode [4];
    int p0;
    vec[0] = 26'h0000001; vcode[0] = 7'h00;
    vec[1] = 26'h0000008; vcode[1] = 7'h03;
    vec[2] = 26'h2000000; vcode[2] = 7'h59;
    vec[3] = 26'h0000006; vcode[3] = 7'h21;

    in_valid = 1'b0; in_req = '0; out_ready = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_code", 32'(out_code), 0);
    check("rst_err_cnt", 32'(err_cnt), 0);
    check("rst_occupancy", 32'(occupancy), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1 check("ready_after_release", 32'(in_ready), 1);
    @(posedge clk); #1;

    // Single requests: latency and fixed codes
    for (int i = 0; i < 4; i++) begin
      send(vec[i], 1'b1);
      check("lat_edge_n", 32'(out_valid), 0);
      step(1'b0, 26'($urandom), 1'b1);
      check("lat_edge_n1", 32'(out_valid), 1);
      check("vec_code", 32'(out_code), 32'(vcode[i]));
      drain();
    end

    // Fill with consumer stalled, then drain in order
    for (int i = 0; i < 4; i++) send(rand_req(0), 1'b0);
    step(1'b0, 26'($urandom), 1'b0);
    check("full_occupancy", 32'(occupancy), 4);
    check("full_in_ready", 32'(in_ready), 0);
    step(1'b0, 26'($urandom), 1'b1);
    check("ready_after_pop", 32'(in_ready), 1);
    check("occ_after_pop", 32'(occupancy), 3);
    drain();

    // Streaming at full rate
    p0 = n_pop;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, rand_req(0), 1'b1);
      check("stream_ready", 32'(in_ready), 1);
      if (i >= 1) begin
        check("stream_occ", 32'(occupancy), 1);
        check("stream_valid", 32'(out_valid), 1);
      end
    end
    in_valid = 1'b0;
    drain();
    check("stream_count", 32'(n_pop - p0), 20);

    // Zero requests interleaved with a one-hot request
    p0 = n_pop;
    send('0, 1'b1); send(26'h0000010, 1'b1); send('0, 1'b1);
    send(26'h0000010, 1'b1); send('0, 1'b1);
    drain();
    check("zero_pulses", 32'(n_pulse), 3);
    check("zero_err_cnt", 32'(err_cnt), 3);
    check("zero_words", 32'(n_pop - p0), 2);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 300; i++)
      step(1'($urandom), rand_req(1), 1'($urandom));
    in_valid = 1'b0;
    drain();
    check("rand_err_cnt", 32'(err_cnt), (nzero > 255) ? 255 : nzero);

    // Saturation of the zero counter
    for (int i = 0; i < 300; i++) send('0, 1'b1);
    drain();
    check("sat_err_cnt", 32'(err_cnt), 255);

    // Mid-operation reset with occupancy 3 and the stage full
    for (int i = 0; i < 4; i++) send(rand_req(0), 1'b0);
    check("pre_rst_occ", 32'(occupancy), 3);
    #2 rst_n = 1'b0;
    exp_q.delete();
    zero_q.delete();
    #1;
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_out_code", 32'(out_code), 0);
    check("midrst_occ", 32'(occupancy), 0);
    check("midrst_in_ready", 32'(in_ready), 0);
    check("midrst_err_cnt", 32'(err_cnt), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", 32'(in_ready), 1);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 26'($urandom), 1'b1);
      check("no_stale_word", 32'(out_valid), 0);
    end
    send(26'h0000008, 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
